// File: rtl/cla_pkg.sv
// Shared configuration helpers and the stage record for the pipelined CLA adder/subtractor.
package cla_pkg;

    localparam int DEF_WIDTH   = 15;
    localparam int DEF_GROUP   = 3;
    localparam int DEF_GPS     = 1;
    localparam int DEF_NGROUPS = DEF_WIDTH / DEF_GROUP;
    localparam int DEF_LAT     = DEF_NGROUPS / DEF_GPS;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Legal only when the word splits evenly into groups and the groups evenly into stages.
    function automatic bit cfg_ok(input int w, input int g, input int gps);
        return (g > 0) && (gps > 0) && (w >= g) && (w % g == 0) && ((w / g) % gps == 0);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [DEF_WIDTH-1:0] sum_lo;
        logic [DEF_WIDTH-1:0] a_hi;
        logic [DEF_WIDTH-1:0] b_hi;
    } stage_rec_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead cell: sum bits, group propagate/generate and per-bit carries.
module cla_group #(
    parameter int GROUP = 3
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             p,
    output logic             g,
    output logic [GROUP-1:0] c
);

    logic [GROUP-1:0] pb;
    logic [GROUP-1:0] gb;

    assign pb = a ^ b;
    assign gb = a & b;
    assign p  = &pb;

    // c[i] is the carry out of bit i, expanded as a flat sum of products over bits 0..i.
    always_comb begin
        logic acc;
        logic pp;
        logic cprev;
        c     = '0;
        s     = '0;
        g     = 1'b0;
        acc   = 1'b0;
        pp    = 1'b1;
        cprev = cin;
        for (int i = 0; i < GROUP; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (gb[j] & pp);
                pp  = pp & pb[j];
            end
            if (i == GROUP - 1) begin
                g = acc;
            end
            c[i]  = acc | (cin & pp);
            s[i]  = pb[i] ^ cprev;
            cprev = c[i];
        end
    end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: GPS groups resolved per stage, carry and
// unresolved operand bits registered between stages, valid/ready stream on both sides.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int GROUP = 3,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NGROUPS = WIDTH / GROUP;
    localparam int LAT     = NGROUPS / GPS;
    localparam int SW      = GPS * GROUP;

    if (!cfg_ok(WIDTH, GROUP, GPS)) begin : g_cfg_err
        $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and WIDTH/GROUP a multiple of GPS");
    end

    logic adv;
    logic ovf_q;
    logic zero_q;

    // Whole pipe moves as one; only a stalled, occupied output holds it.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int WS = WIDTH - s * SW;
        localparam int HW = WS - SW;

        logic [WS-1:0]         src_a;
        logic [WS-1:0]         src_b;
        logic                  cs;
        logic                  vin;
        logic [GPS-1:0]        gp;
        logic [GPS-1:0]        gg;
        logic [GPS:0]          gc;
        logic [SW-1:0]         ssum;
        logic [SW-1:0]         bc;
        logic                  bc_unused;
        logic [(s+1)*SW-1:0]   sum_nx;
        logic [(s+1)*SW-1:0]   sum_q;
        logic                  vld_q;
        logic                  carry_q;

        // Stage 0 captures the operands; subtraction is A + ~B + 1.
        if (s == 0) begin : g_src
            assign vin    = in_valid;
            assign src_a  = a;
            assign src_b  = b ^ {WIDTH{sub}};
            assign cs     = sub | c_in;
            assign sum_nx = ssum;
        end else begin : g_src
            assign vin    = g_stage[s-1].vld_q;
            assign src_a  = g_stage[s-1].g_skew.a_q;
            assign src_b  = g_stage[s-1].g_skew.b_q;
            assign cs     = g_stage[s-1].carry_q;
            assign sum_nx = {ssum, g_stage[s-1].sum_q};
        end

        for (genvar k = 0; k < GPS; k++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a  (src_a[k*GROUP +: GROUP]),
                .b  (src_b[k*GROUP +: GROUP]),
                .cin(gc[k]),
                .s  (ssum[k*GROUP +: GROUP]),
                .p  (gp[k]),
                .g  (gg[k]),
                .c  (bc[k*GROUP +: GROUP])
            );
        end

        always_comb begin
            logic acc;
            logic pp;
            gc    = '0;
            gc[0] = cs;
            acc   = 1'b0;
            pp    = 1'b1;
            for (int k = 1; k <= GPS; k++) begin
                acc = 1'b0;
                pp  = 1'b1;
                for (int j = k - 1; j >= 0; j--) begin
                    acc = acc | (gg[j] & pp);
                    pp  = pp & gp[j];
                end
                gc[k] = acc | (cs & pp);
            end
        end

        assign bc_unused = ^bc;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= vin;
            end
        end

        // ---- stage register boundary ----
        if (s < LAT - 1) begin : g_skew
            logic [HW-1:0] a_q;
            logic [HW-1:0] b_q;
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q     <= src_a[WS-1:SW];
                    b_q     <= src_b[WS-1:SW];
                    sum_q   <= sum_nx;
                    carry_q <= gc[GPS];
                end
            end
        end else begin : g_last
            logic c_msb;
            if (SW > 1) begin : g_cm
                assign c_msb = bc[SW-2];
            end else begin : g_cm
                assign c_msb = cs;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    zero_q  <= 1'b0;
                end else if (adv) begin
                    sum_q   <= sum_nx;
                    carry_q <= gc[GPS];
                    ovf_q   <= c_msb ^ gc[GPS];
                    zero_q  <= ~|sum_nx;
                end
            end
        end
    end

    assign out_valid = g_stage[LAT-1].vld_q;
    assign sum       = g_stage[LAT-1].sum_q;
    assign c_out     = g_stage[LAT-1].carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe at default parameters, with an arithmetic reference model.
module tb_cla_addsub_pipe;

    localparam int W       = 15;
    localparam int LATENCY = 5;
    localparam int MASK    = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sbq[$];

    cla_addsub_pipe #(.WIDTH(W), .GROUP(3), .GPS(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
    function automatic exp_t model(input int ai, input int bi, input bit s, input bit ci);
        exp_t e;
        int r, sa, sb, sr;
        sa = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
        sb = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
        if (s) begin
            r   = ai - bi;
            e.c = (ai >= bi);
            sr  = sa - sb;
        end else begin
            r   = ai + bi + int'(ci);
            e.c = (r > MASK);
            sr  = sa + sb + int'(ci);
        end
        e.sum = r[W-1:0];
        e.v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.z   = (e.sum == '0);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send(input int av, input int bv, input bit s, input bit ci, input bit lat);
        exp_t e;
        bit   done;
        done     = 1'b0;
        a        = av[W-1:0];
        b        = bv[W-1:0];
        sub      = s;
        c_in     = ci;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            #4;
            if (in_ready) begin
                e     = model(av, bv, s, ci);
                e.acc = cyc;
                e.lat = lat;
                sbq.push_back(e);
                done  = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 100 cycles");
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && sbq.size() > 0; t++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sbq.size());
        end
    endtask

    // Monitor: compares every accepted output beat and checks stall behaviour.
    initial begin
        logic [W-1:0] held_sum;
        bit           held;
        exp_t         e;
        held     = 1'b0;
        held_sum = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_sum", 32'(sum), 32'(held_sum));
                end
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    held     = 1'b1;
                    held_sum = sum;
                end else begin
                    held = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_beat: got sum=0x%0h, required no beat", sum);
                    end else begin
                        e = sbq.pop_front();
                        chk("sum", 32'(sum), 32'(e.sum));
                        chk("c_out", 32'(c_out), 32'(e.c));
                        chk("ovf", 32'(ovf), 32'(e.v));
                        chk("zero", 32'(zero), 32'(e.z));
                        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(LATENCY));
                    end
                end
            end
        end
    end

    int dir_tab [8][4] = '{
        '{32'h0001, 32'h0002, 0, 0},
        '{32'h7FFF, 32'h0001, 0, 0},
        '{32'h3FFF, 32'h0001, 0, 0},
        '{32'h0007, 32'h0005, 1, 0},
        '{32'h0005, 32'h0007, 1, 0},
        '{32'h1234, 32'h1234, 1, 0},
        '{32'h1234, 32'h1234, 1, 1},
        '{32'h0FFF, 32'h7000, 0, 1}
    };

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2] != 0, dir_tab[i][3] != 0, 1'b1);
            wait_drain();
        end

        for (int i = 0; i < 100; i++) begin
            send(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_drain();

        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                end
            end
            begin
                repeat (12) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with beats in flight and one held at the output.
        out_ready = 1'b0;
        send(32'h3FFF, 32'h0001, 1'b0, 1'b0, 1'b0);
        send(32'h0007, 32'h0005, 1'b1, 1'b0, 1'b0);
        send(32'h1234, 32'h4321, 1'b0, 1'b1, 1'b0);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = out_valid;
        end
        chk("inflight_out_valid", 32'(got), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_sum", 32'(sum), 32'd0);
        chk("async_c_out", 32'(c_out), 32'd0);
        chk("async_ovf", 32'(ovf), 32'd0);
        chk("async_zero", 32'(zero), 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #4;
            chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
